// File: rtl/uart_wb_fifo.sv
// uart_wb_fifo: Wishbone slave with TX/RX byte FIFOs in front of the uart core.
// Optional interrupt output is built when UART_FIFO_IRQ_EN is defined.
module uart_wb_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        uart_wr,
    output logic        uart_rd,
    output logic [1:0]  uart_adr,
    output logic [7:0]  uart_din,
    input  logic [7:0]  uart_dout,
`ifdef UART_FIFO_IRQ_EN
    output logic        irq_o,
`endif
    input  logic [7:0]  uart_dout1
);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_BUSY
    } tx_state_t;

    typedef enum logic {
        RX_IDLE,
        RX_ACK
    } rx_state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // storage and pointers
    logic [7:0]    r_tx_mem [DEPTH];
    logic [AW-1:0] r_tx_wp;
    logic [AW-1:0] r_tx_rp;
    logic [AW:0]   r_tx_cnt;
    logic [7:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_rx_wp;
    logic [AW-1:0] r_rx_rp;
    logic [AW:0]   r_rx_cnt;

    // bus side
    logic          r_ack;
    logic [31:0]   r_dat;
    logic          r_ovr;
    logic          r_drop;

    // uart side
    tx_state_t     r_tx_st;
    logic          r_tx_skip;
    rx_state_t     r_rx_st;
    logic          r_wr;
    logic          r_rd;
    logic [7:0]    r_din;

    logic          w_acc;
    logic          w_wr_data;
    logic          w_rd_data;
    logic          w_wr_clr;
    logic          w_stat_ok;
    logic          w_busy;
    logic          w_dok;
    logic          w_tx_empty;
    logic          w_tx_full;
    logic          w_tx_pop;
    logic          w_tx_push;
    logic          w_tx_drop;
    logic          w_rx_empty;
    logic          w_rx_full;
    logic          w_rx_cap;
    logic          w_rx_pop;
    logic          w_rx_push;
    logic          w_rx_ovr;
    logic [3:0]    w_rx_cnt4;
    logic [31:0]   w_status;
    logic          w_unused_ok;

    assign w_acc     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr_data = w_acc & wb_we_i & (wb_adr_i == 2'd0);
    assign w_rd_data = w_acc & ~wb_we_i & (wb_adr_i == 2'd0);
    assign w_wr_clr  = w_acc & wb_we_i & (wb_adr_i == 2'd2);

    // The status view is only on the bus while no strobe is driving adr 00.
    assign w_stat_ok = ~r_wr & ~r_rd;
    assign w_busy    = uart_dout1[1];
    assign w_dok     = uart_dout1[0];

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == FULL_CNT);
    assign w_tx_pop   = (r_tx_st == TX_LOAD) & ~w_tx_empty;
    assign w_tx_push  = w_wr_data & (~w_tx_full | w_tx_pop);
    assign w_tx_drop  = w_wr_data & w_tx_full & ~w_tx_pop;

    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == FULL_CNT);
    assign w_rx_cap   = (r_rx_st == RX_IDLE) & w_stat_ok & w_dok;
    assign w_rx_pop   = w_rd_data & ~w_rx_empty;
    assign w_rx_push  = w_rx_cap & (~w_rx_full | w_rx_pop);
    assign w_rx_ovr   = w_rx_cap & w_rx_full & ~w_rx_pop;

    assign w_rx_cnt4 = 4'(r_rx_cnt);
    assign w_status  = {20'b0, w_rx_cnt4, 2'b00, r_drop, r_ovr,
                        w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};

    assign w_unused_ok = ^{wb_dat_i[31:8], wb_dat_i[3:0], uart_dout1[7:2]};

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign uart_wr  = r_wr;
    assign uart_rd  = r_rd;
    assign uart_din = r_din;
    assign uart_adr = (r_wr | r_rd) ? 2'b00 : 2'b01;

    // FIFO storage writes; contents need no reset since counts gate reads
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= wb_dat_i[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wp] <= uart_dout;
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + (AW+1)'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - (AW+1)'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + (AW+1)'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - (AW+1)'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // Wishbone ack and registered read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_acc;
            r_dat <= '0;
            if (w_acc && !wb_we_i) begin
                case (wb_adr_i)
                    2'd0: r_dat <= {24'b0, w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp]};
                    2'd1: r_dat <= w_status;
                    default: r_dat <= '0;
                endcase
            end
        end
    end

    // Sticky error flags; a new event wins over a clear on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovr  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            if (w_rx_ovr)
                r_ovr <= 1'b1;
            else if (w_wr_clr && wb_dat_i[4])
                r_ovr <= 1'b0;
            if (w_tx_drop)
                r_drop <= 1'b1;
            else if (w_wr_clr && wb_dat_i[5])
                r_drop <= 1'b0;
        end
    end

    // TX pacing: one byte per UART busy period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_st   <= TX_IDLE;
            r_tx_skip <= 1'b0;
            r_wr      <= 1'b0;
            r_din     <= '0;
        end else begin
            case (r_tx_st)
                TX_IDLE: begin
                    if (!w_tx_empty && w_stat_ok && !w_busy) begin
                        r_tx_st <= TX_LOAD;
                        r_wr    <= 1'b1;
                        r_din   <= r_tx_mem[r_tx_rp];
                    end
                end
                TX_LOAD: begin
                    r_wr      <= 1'b0;
                    r_tx_skip <= 1'b1;
                    r_tx_st   <= TX_BUSY;
                end
                TX_BUSY: begin
                    if (r_tx_skip)
                        r_tx_skip <= 1'b0;
                    else if (w_stat_ok && !w_busy)
                        r_tx_st <= TX_IDLE;
                end
                default: begin
                    r_tx_st <= TX_IDLE;
                    r_wr    <= 1'b0;
                end
            endcase
        end
    end

    // RX drain: capture on data-ok, then one read strobe to clear it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_st <= RX_IDLE;
            r_rd    <= 1'b0;
        end else begin
            case (r_rx_st)
                RX_IDLE: begin
                    if (w_rx_cap) begin
                        r_rx_st <= RX_ACK;
                        r_rd    <= 1'b1;
                    end
                end
                RX_ACK: begin
                    r_rd    <= 1'b0;
                    r_rx_st <= RX_IDLE;
                end
                default: begin
                    r_rd    <= 1'b0;
                    r_rx_st <= RX_IDLE;
                end
            endcase
        end
    end

`ifdef UART_FIFO_IRQ_EN
    logic w_rd_stat;
    logic r_tx_sent;
    logic r_ovr_pend;
    logic r_irq;

    assign w_rd_stat = w_acc & ~wb_we_i & (wb_adr_i == 2'd1);
    assign irq_o     = r_irq;

    // Event-type causes latch until software reads STATUS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_sent  <= 1'b0;
            r_ovr_pend <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_tx_pop)
                r_tx_sent <= 1'b1;
            else if (w_rd_stat)
                r_tx_sent <= 1'b0;
            if (w_rx_ovr)
                r_ovr_pend <= 1'b1;
            else if (w_rd_stat)
                r_ovr_pend <= 1'b0;
            r_irq <= ~w_rx_empty | r_ovr_pend | (w_tx_empty & r_tx_sent);
        end
    end
`endif

endmodule

// File: tb/tb_uart_wb_fifo.sv
// Bench for uart_wb_fifo: queue-based model of both FIFOs and flags,
// plus a behavioural uart with a busy timer and a byte feed.
module tb_uart_wb_fifo;

    localparam int DEPTH    = 16;
    localparam int BUSY_LEN = 6;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic [1:0]  wb_adr_i = 2'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        uart_wr;
    logic        uart_rd;
    logic [1:0]  uart_adr;
    logic [7:0]  uart_din;
    logic [7:0]  uart_dout;
    logic [7:0]  uart_dout1;
`ifdef UART_FIFO_IRQ_EN
    logic        irq_o;
`endif

    always #5 clk = ~clk;

    uart_wb_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .uart_wr    (uart_wr),
        .uart_rd    (uart_rd),
        .uart_adr   (uart_adr),
        .uart_din   (uart_din),
        .uart_dout  (uart_dout),
`ifdef UART_FIFO_IRQ_EN
        .irq_o      (irq_o),
`endif
        .uart_dout1 (uart_dout1)
    );

    // behavioural uart
    logic       hold_busy = 1'b0;
    logic       u_busy    = 1'b0;
    logic       u_pend    = 1'b0;
    logic       u_dok     = 1'b0;
    logic [7:0] u_rxd     = 8'h00;
    int         u_cnt     = 0;
    logic [7:0] feed [0:31];
    int         feed_n    = 0;
    int         feed_i    = 0;
    int         sent_n    = 0;
    int         rd_n      = 0;

    always @(posedge clk) begin
        if (uart_wr) begin
            u_pend <= 1'b1;
            sent_n <= sent_n + 1;
        end
        if (u_pend) begin
            u_busy <= 1'b1;
            u_cnt  <= BUSY_LEN;
            u_pend <= 1'b0;
        end else if (u_busy) begin
            if (u_cnt == 0) u_busy <= 1'b0;
            else u_cnt <= u_cnt - 1;
        end
        if (uart_rd) begin
            u_dok <= 1'b0;
            rd_n  <= rd_n + 1;
        end else if (!u_dok && feed_i < feed_n) begin
            u_dok  <= 1'b1;
            u_rxd  <= feed[feed_i];
            feed_i <= feed_i + 1;
        end
    end

    assign uart_dout  = u_rxd;
    assign uart_dout1 = {6'b0, u_busy | hold_busy, u_dok};

    // model state
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_tx [$];
    logic [7:0]  exp_rx [$];
    logic [7:0]  tx_log [$];
    bit          m_ovr   = 1'b0;
    bit          m_drop  = 1'b0;
    bit          saw_ack = 1'b0;
    logic [31:0] last_rd = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] status_model();
        logic [31:0] s;
        int rc;
        rc = exp_rx.size();
        s = 32'd0;
        s[0] = (exp_tx.size() == 0);
        s[1] = (exp_tx.size() == DEPTH);
        s[2] = (rc == 0);
        s[3] = (rc == DEPTH);
        s[4] = m_ovr;
        s[5] = m_drop;
        s[11:8] = 4'(rc);
        return s;
    endfunction

    // one clock: check outputs mid-cycle, update model, return 1 after edge
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (!rst) begin
            chk("rst_outs", 32'({wb_ack_o, uart_wr, uart_rd, uart_adr, uart_din}),
                32'h100);
            chk("rst_dat", wb_dat_o, 32'd0);
            exp_tx.delete();
            exp_rx.delete();
            m_ovr  = 1'b0;
            m_drop = 1'b0;
        end else begin
            if (wb_ack_o) begin
                saw_ack = 1'b1;
                if (wb_we_i) begin
                    if (wb_adr_i == 2'd0) begin
                        if (exp_tx.size() < DEPTH) exp_tx.push_back(wb_dat_i[7:0]);
                        else m_drop = 1'b1;
                    end else if (wb_adr_i == 2'd2) begin
                        if (wb_dat_i[4]) m_ovr = 1'b0;
                        if (wb_dat_i[5]) m_drop = 1'b0;
                    end
                end else begin
                    e = 32'd0;
                    if (wb_adr_i == 2'd0 && exp_rx.size() > 0)
                        e = {24'd0, exp_rx.pop_front()};
                    else if (wb_adr_i == 2'd1)
                        e = status_model();
                    last_rd = wb_dat_o;
                    chk("rd_data", wb_dat_o, e);
                end
            end
            if (uart_wr) begin
                tx_log.push_back(uart_din);
                chk("tx_queued", 32'(exp_tx.size() > 0), 32'd1);
                if (exp_tx.size() > 0)
                    chk("tx_byte", 32'(uart_din), 32'(exp_tx.pop_front()));
                chk("tx_paced", 32'({u_busy, u_pend, hold_busy}), 32'd0);
            end
            if (uart_rd) begin
                chk("rd_has_data", 32'(u_dok), 32'd1);
                if (exp_rx.size() < DEPTH) exp_rx.push_back(u_rxd);
                else m_ovr = 1'b1;
            end
            chk("uart_adr", 32'(uart_adr),
                32'((uart_wr | uart_rd) ? 2'b00 : 2'b01));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = w;
        wb_adr_i = a;
        wb_dat_i = d;
        saw_ack  = 1'b0;
        tick();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        tick();
        chk("ack_seen", 32'(saw_ack), 32'd1);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        bus(1'b0, 2'd1, 32'd0);
        chk("status_reset", last_rd, 32'h005);

        // three back-to-back TX bytes
        bus(1'b1, 2'd0, 32'h41);
        bus(1'b1, 2'd0, 32'h42);
        bus(1'b1, 2'd0, 32'h43);
        for (int i = 0; i < 400 && !(exp_tx.size() == 0 && !u_busy && !u_pend); i++)
            tick();
        chk("tx_drain_timeout", 32'(exp_tx.size()), 32'd0);
        repeat (3) tick();
        chk("tx_count", 32'(tx_log.size()), 32'd3);
        chk("tx_b0", 32'(tx_log[0]), 32'h41);
        chk("tx_b1", 32'(tx_log[1]), 32'h42);
        chk("tx_b2", 32'(tx_log[2]), 32'h43);
        bus(1'b0, 2'd1, 32'd0);
        chk("status_tx_done", last_rd, 32'h005);

        // TX overflow while uart busy
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) bus(1'b1, 2'd0, 32'h60 + i);
        bus(1'b0, 2'd1, 32'd0);
        chk("status_tx_full", last_rd, 32'h026);
        bus(1'b1, 2'd2, 32'h20);
        bus(1'b0, 2'd1, 32'd0);
        chk("status_drop_clr", last_rd, 32'h006);
        hold_busy = 1'b0;
        for (int i = 0; i < 1000 && !(exp_tx.size() == 0 && !u_busy && !u_pend); i++)
            tick();
        chk("tx_full_drain_timeout", 32'(exp_tx.size()), 32'd0);
        repeat (3) tick();
        chk("tx_full_count", 32'(tx_log.size()), 32'd19);
        chk("tx_full_last", 32'(tx_log[18]), 32'h6F);
        bus(1'b0, 2'd1, 32'd0);
        chk("status_full_done", last_rd, 32'h005);

        // single RX byte
        feed[0] = 8'h5A;
        feed_n = 1;
        for (int i = 0; i < 200 && rd_n < 1; i++) tick();
        repeat (5) tick();
        chk("rx_rd_pulses", rd_n, 1);
        bus(1'b0, 2'd1, 32'd0);
        chk("status_rx1", last_rd, 32'h101);
        bus(1'b0, 2'd0, 32'd0);
        chk("rx_data", last_rd, 32'h5A);
        bus(1'b0, 2'd1, 32'd0);
        chk("status_rx_done", last_rd, 32'h005);
        bus(1'b0, 2'd0, 32'd0);
        chk("rx_empty_read", last_rd, 32'h0);

        // RX overrun
        for (int i = 0; i < 17; i++) feed[1 + i] = 8'(8'h80 + i);
        feed_n = 18;
        for (int i = 0; i < 600 && rd_n < 18; i++) tick();
        repeat (5) tick();
        chk("rx_ovr_pulses", rd_n, 18);
        bus(1'b0, 2'd1, 32'd0);
        chk("status_rx_full", last_rd, 32'h019);
        for (int i = 0; i < 16; i++) begin
            bus(1'b0, 2'd0, 32'd0);
            chk("rx_order", last_rd, 32'h80 + i);
        end
        bus(1'b0, 2'd1, 32'd0);
        chk("status_rx_drained", last_rd, 32'h015);
        bus(1'b1, 2'd2, 32'h10);
        bus(1'b0, 2'd1, 32'd0);
        chk("status_ovr_clr", last_rd, 32'h005);

        // reset in the middle of a TX byte
        bus(1'b1, 2'd0, 32'h99);
        bus(1'b1, 2'd0, 32'h9A);
        for (int i = 0; i < 100 && tx_log.size() < 20; i++) tick();
        chk("rst_tx_started", 32'(tx_log.size()), 32'd20);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_async_outs", 32'({uart_wr, uart_rd, uart_adr}), 32'b0001);
        repeat (2) tick();
        rst = 1'b1;
        n = sent_n;
        repeat (40) tick();
        chk("no_wr_after_rst", sent_n, n);
        chk("tx_log_after_rst", 32'(tx_log.size()), 32'd20);
        bus(1'b0, 2'd1, 32'd0);
        chk("status_after_rst", last_rd, 32'h005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
